// File: rtl/updown_counter_hex.sv
// Up/down counter with parallel load, terminal-count flag and registered seven-segment decode.
// Define UPDOWN_COUNTER_SAT_EN to saturate at the bounds instead of wrapping.
module updown_counter_hex #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH - 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [WIDTH-1:0]        load_val,
    output logic [WIDTH-1:0]        count,
    output logic                    tc,
    output logic [7*(WIDTH/4)-1:0]  hex
);

    localparam int                    DIGITS  = WIDTH / 4;
    localparam logic [WIDTH-1:0]      MAX_C   = WIDTH'(MAX_VAL);
    localparam logic [7*DIGITS-1:0]   HEX_RST = {DIGITS{7'b1000000}};

    // Active-low segments, bit 0 = segment a.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'b1111111;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [WIDTH-1:0]    count_next;
    logic [7*DIGITS-1:0] hex_next;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = (load_val > MAX_C) ? MAX_C : load_val;
        end else if (en) begin
            if (up) begin
                if (count > MAX_C) begin
                    count_next = '0;
                end else if (count == MAX_C) begin
`ifdef UPDOWN_COUNTER_SAT_EN
                    count_next = MAX_C;
`else
                    count_next = '0;
`endif
                end else begin
                    count_next = count + 1'b1;
                end
            end else begin
                if (count > MAX_C) begin
                    count_next = MAX_C;
                end else if (count == '0) begin
`ifdef UPDOWN_COUNTER_SAT_EN
                    count_next = '0;
`else
                    count_next = MAX_C;
`endif
                end else begin
                    count_next = count - 1'b1;
                end
            end
        end
    end

    always_comb begin
        hex_next = HEX_RST;
        for (int k = 0; k < DIGITS; k++) begin
            hex_next[7*k +: 7] = seg7(count[4*k +: 4]);
        end
    end

    // tc is gated by rst_n so it reads low throughout reset, not only after it.
    assign tc = rst_n & en & ~load &
                ((up & (count == MAX_C)) | (~up & (count == '0)));

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            hex   <= HEX_RST;
        end else begin
            count <= count_next;
            hex   <= hex_next;
        end
    end

endmodule

// File: tb/tb_updown_counter_hex.sv
// Scoreboard bench for updown_counter_hex: three instances (8-bit/255, 4-bit/9, 16-bit) share clk and rst_n.
module tb_updown_counter_hex;

`ifdef UPDOWN_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        string       name;
        int          dut;
        logic [15:0] cnt;
        logic        tc;
        logic [27:0] hex;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic rst_n;

    logic        en0, up0, load0;
    logic [7:0]  load_val0, count0;
    logic        tc0;
    logic [13:0] hex0;

    logic        en1, up1, load1;
    logic [3:0]  load_val1, count1;
    logic        tc1;
    logic [6:0]  hex1;

    logic        en2, up2, load2;
    logic [15:0] load_val2, count2;
    logic        tc2;
    logic [27:0] hex2;

    always #5 clk = ~clk;

    updown_counter_hex #(.WIDTH(8), .MAX_VAL(255)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en0), .up(up0), .load(load0),
        .load_val(load_val0), .count(count0), .tc(tc0), .hex(hex0)
    );

    updown_counter_hex #(.WIDTH(4), .MAX_VAL(9)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en1), .up(up1), .load(load1),
        .load_val(load_val1), .count(count1), .tc(tc1), .hex(hex1)
    );

    updown_counter_hex #(.WIDTH(16), .MAX_VAL(65535)) dut16 (
        .clk(clk), .rst_n(rst_n), .en(en2), .up(up2), .load(load2),
        .load_val(load_val2), .count(count2), .tc(tc2), .hex(hex2)
    );

    function automatic logic [27:0] hx(input logic [15:0] v, input int digits);
        logic [27:0] r;
        logic [3:0]  nib;
        r = '0;
        for (int k = 0; k < digits; k++) begin
            nib = v[4*k +: 4];
            r[7*k +: 7] = SEG_TAB[nib];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input string name, input int dut, input logic [15:0] c,
                        input logic t, input logic [27:0] h);
        exp_t e;
        e.name = name;
        e.dut  = dut;
        e.cnt  = c;
        e.tc   = t;
        e.hex  = h;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] ac;
        logic        at;
        logic [27:0] ah;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin ac = 16'(count0); at = tc0; ah = 28'(hex0); end
                1:       begin ac = 16'(count1); at = tc1; ah = 28'(hex1); end
                default: begin ac = count2;      at = tc2; ah = hex2;      end
            endcase
            check({e.name, "_count"}, 32'(ac), 32'(e.cnt));
            check({e.name, "_tc"},    32'(at), 32'(e.tc));
            check({e.name, "_hex"},   32'(ah), 32'(e.hex));
        end
    end

    initial begin
        rst_n = 1'b0;
        en0 = 1'b1; up0 = 1'b0; load0 = 1'b0; load_val0 = '0;
        en1 = 1'b0; up1 = 1'b0; load1 = 1'b0; load_val1 = '0;
        en2 = 1'b0; up2 = 1'b0; load2 = 1'b0; load_val2 = '0;

        // In reset: tc must stay low even though en/up/count would otherwise raise it.
        push("rst8",  0, 16'h0000, 1'b0, hx(16'h0, 2));
        push("rst4",  1, 16'h0000, 1'b0, hx(16'h0, 1));
        push("rst16", 2, 16'h0000, 1'b0, hx(16'h0, 4));

        #12;
        en0   = 1'b0;
        rst_n = 1'b1;

        step();
        en0 = 1'b1;
        up0 = 1'b1;
        push("up_start", 0, 16'h0000, 1'b0, hx(16'h0, 2));

        for (int i = 1; i <= 256; i++) begin
            step();
            if (i == 256) begin
                load0     = 1'b1;
                load_val0 = 8'h35;
                up0       = 1'b0;
            end
            push($sformatf("up%0d", i), 0, 16'(i % 256), (i % 256) == 255,
                 hx(16'((i - 1) % 256), 2));
        end

        step();
        load0 = 1'b0;
        en0   = 1'b0;
        push("load35", 0, 16'h0035, 1'b0, hx(16'h00, 2));

        step();
        load0     = 1'b1;
        load_val0 = 8'h7A;
        push("hold35", 0, 16'h0035, 1'b0, hx(16'h35, 2));

        step();
        load0 = 1'b0;
        push("load7a", 0, 16'h007A, 1'b0, hx(16'h35, 2));

        // Asynchronous reset pulse between edges; checked at the falling edge before the next rise.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        push("async_rst", 0, 16'h0000, 1'b0, hx(16'h00, 2));
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        step();
        en0 = 1'b1;
        up0 = 1'b0;
        push("down_at0", 0, 16'h0000, 1'b1, hx(16'h00, 2));

        step();
        push("down_wrap", 0, SAT ? 16'h0000 : 16'h00FF, SAT,
             hx(16'h00, 2));

        step();
        en0 = 1'b0;
        push("down_next", 0, SAT ? 16'h0000 : 16'h00FE, 1'b0,
             hx(SAT ? 16'h00 : 16'hFF, 2));

        step();
        load1     = 1'b1;
        load_val1 = 4'hC;
        push("ld4_issue", 1, 16'h0, 1'b0, hx(16'h0, 1));

        step();
        load1 = 1'b0;
        en1   = 1'b1;
        up1   = 1'b1;
        push("ld4_clamp", 1, 16'h9, 1'b1, hx(16'h0, 1));

        step();
        push("wrap4", 1, SAT ? 16'h9 : 16'h0, SAT, 28'(7'b0010000));

        step();
        push("wrap4_next", 1, SAT ? 16'h9 : 16'h1, SAT, hx(SAT ? 16'h9 : 16'h0, 1));

        step();
        load2     = 1'b1;
        load_val2 = 16'h1234;
        push("ld16_issue", 2, 16'h0000, 1'b0, hx(16'h0, 4));

        step();
        load2 = 1'b0;
        en2   = 1'b1;
        up2   = 1'b1;
        push("ld16", 2, 16'h1234, 1'b0, hx(16'h0000, 4));

        for (int j = 1; j <= 6; j++) begin
            step();
            up2 = (j % 2 == 0);
            push($sformatf("alt%0d", j), 2,
                 (j % 2 == 1) ? 16'h1235 : 16'h1234, 1'b0,
                 hx((j % 2 == 1) ? 16'h1234 : 16'h1235, 4));
        end

        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
